// File: rtl/button_shaper.sv
// button_shaper: turns one raw, active-low, bouncing pushbutton into a
// one-cycle press pulse (B) and a debounced pressed level (held).
// Optional auto-repeat (extra B pulses while held) is compiled in when the
// macro BUTTON_REPEAT_EN is defined; without it there is one pulse per press.
module button_shaper #(
  parameter int DB_CYCLES     = 1000000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 10000000,
  parameter int CNT_W         = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic B,
  output logic held
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    PRESSED    = 2'd2,
    DB_RELEASE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  // Reject parameter sets the counters cannot represent or that would let
  // B stay high on consecutive cycles.
  if (DB_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2 || CNT_W < 1 ||
      CNT_W > 30 || (DB_CYCLES - 1) > ((1 << CNT_W) - 1) ||
      (REPEAT_DELAY - 1) > ((1 << CNT_W) - 1) ||
      (REPEAT_PERIOD - 1) > ((1 << CNT_W) - 1)) begin : g_bad_params
    $error("button_shaper: invalid DB_CYCLES/REPEAT_*/CNT_W combination");
  end

  logic btn_n_p0;
  logic btn_n_p1;
  logic s;
  state_t state;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchronizer; both stages rest at 1 (released).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_n_p0 <= 1'b1;
      btn_n_p1 <= 1'b1;
    end else begin
      btn_n_p0 <= btn_n;
      btn_n_p1 <= btn_n_p0;
    end
  end

  assign s = btn_n_p1;

`ifdef BUTTON_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] rpt;
  logic             rpt_first;
`endif

  // Debounce FSM; B and held are registered straight from the transition taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      B     <= 1'b0;
      held  <= 1'b0;
`ifdef BUTTON_REPEAT_EN
      rpt       <= '0;
      rpt_first <= 1'b1;
`endif
    end else begin
      B <= 1'b0;
      case (state)
        IDLE: begin
          held <= 1'b0;
          if (!s) begin
            state <= DB_PRESS;
            cnt   <= '0;
          end
        end
        DB_PRESS: begin
          held <= 1'b0;
          if (s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state <= PRESSED;
            B     <= 1'b1;
            held  <= 1'b1;
`ifdef BUTTON_REPEAT_EN
            rpt       <= '0;
            rpt_first <= 1'b1;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          held <= 1'b1;
          if (s) begin
            state <= DB_RELEASE;
            cnt   <= '0;
          end else begin
`ifdef BUTTON_REPEAT_EN
            // First repeat waits the long delay, later ones the short period.
            if (rpt == (rpt_first ? RPT_DELAY_LAST : RPT_PERIOD_LAST)) begin
              B         <= 1'b1;
              rpt       <= '0;
              rpt_first <= 1'b0;
            end else begin
              rpt <= rpt + 1'b1;
            end
`endif
          end
        end
        DB_RELEASE: begin
          held <= 1'b1;
          if (!s) begin
            // Release was a glitch: back to held, no new press pulse.
            state <= PRESSED;
`ifdef BUTTON_REPEAT_EN
            rpt       <= '0;
            rpt_first <= 1'b1;
`endif
          end else if (cnt == DB_LAST) begin
            state <= IDLE;
            held  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          held  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
